// File: rtl/spmv_axi_pkg.sv
// Shared AXI definitions for the SpMV memory-side blocks.
// Contents: AXI burst/response/cache encodings, the write-coalescer FSM
// state type, and a constant-foldable clog2 helper for port/index sizing.
package spmv_axi_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0010;

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_FLUSH_AW = 2'd1,
    ST_FLUSH_W  = 2'd2,
    ST_FLUSH_B  = 2'd3
  } wr_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/axi_wr_line_buf.sv
// One-line write buffer: BURST_LEN*R narrow words of data plus a per-byte
// valid mask.
// Ports:
//   clk, rstn            clock, synchronous active-low reset (clears mask only)
//   wr_en/wr_word/wr_data/wr_strb  byte-granular narrow write
//   clear                drop the whole mask (line retired)
//   rd_beat              wide beat index; rd_data/rd_strb are that beat's
//                        words (lowest word index in the LSBs) and mask bits
//   full                 every byte of the line has been written
module axi_wr_line_buf
  import spmv_axi_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int S_DW      = 32,
  parameter int M_DW      = 256,
  localparam int R        = M_DW / S_DW,
  localparam int WORDS    = BURST_LEN * R,
  localparam int S_BYTES  = S_DW / 8,
  localparam int M_BYTES  = M_DW / 8,
  localparam int WI       = clog2(WORDS),
  localparam int BI       = clog2(BURST_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [WI-1:0]      wr_word,
  input  logic [S_DW-1:0]    wr_data,
  input  logic [S_BYTES-1:0] wr_strb,
  input  logic               clear,
  input  logic [BI-1:0]      rd_beat,
  output logic [M_DW-1:0]    rd_data,
  output logic [M_BYTES-1:0] rd_strb,
  output logic               full
);

  logic [WORDS-1:0][S_DW-1:0]    data_q, data_d;
  logic [WORDS-1:0][S_BYTES-1:0] mask_q, mask_d;

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (clear) begin
      mask_d = '0;
    end else if (wr_en) begin
      for (int b = 0; b < S_BYTES; b++) begin
        if (wr_strb[b]) begin
          data_d[wr_word][b*8 +: 8] = wr_data[b*8 +: 8];
          mask_d[wr_word][b]        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_strb = '0;
    for (int j = 0; j < R; j++) begin
      rd_data[j*S_DW +: S_DW]       = data_q[WI'(int'(rd_beat) * R + j)];
      rd_strb[j*S_BYTES +: S_BYTES] = mask_q[WI'(int'(rd_beat) * R + j)];
    end
  end

  assign full = &mask_q;

  // Data is qualified by the mask, so only the mask needs a reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (!rstn) mask_q <= '0;
    else       mask_q <= mask_d;
  end

endmodule

// File: rtl/axi_wr_coalesce.sv
// Narrow-to-wide AXI write coalescer. Single-beat 32b writes are merged by
// byte into a one-line buffer; the line leaves as one INCR burst of BURST_LEN
// wide beats when full, on a miss, on idle timeout, or on flush_req.
// Ports: clk/rstn (sync active-low), s_axi_* narrow slave (AW+W taken together,
// posted B), m_axi_* wide master, flush_req pulse, idle and sticky err status.
//
// state       | meaning
// ST_COLLECT  | accepting narrow writes into the open line
// ST_FLUSH_AW | wide AW presented with the current line address
// ST_FLUSH_W  | streaming BURST_LEN wide beats from the buffer
// ST_FLUSH_B  | waiting for the wide write response
module axi_wr_coalesce
  import spmv_axi_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 48,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 256,
  parameter int C_FLUSH_TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_M_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awlock,
  output logic [3:0]                      m_axi_awcache,
  output logic [2:0]                      m_axi_awprot,
  output logic [3:0]                      m_axi_awqos,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic                            flush_req,
  output logic                            idle,
  output logic                            err
);

  localparam int AW         = C_M_AXI_ADDR_WIDTH;
  localparam int LINE_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
  localparam int LB         = clog2(LINE_BYTES);
  localparam int SB         = clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int WI         = LB - SB;
  localparam int BI         = clog2(C_M_AXI_BURST_LEN);
  localparam int TW         = clog2(C_FLUSH_TIMEOUT + 1);
  localparam int M_SIZE     = clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam logic [BI-1:0] LAST_BEAT = BI'(C_M_AXI_BURST_LEN - 1);

  wr_state_e                   state_q, state_d;
  logic                        open_q, open_d;
  logic [AW-1:0]               cur_line_q, cur_line_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        pend_q, pend_d;
  logic [BI-1:0]               beat_q, beat_d;
  logic                        bvalid_q, bvalid_d;
  logic [C_M_AXI_ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        err_q, err_d;

  logic [AW-1:0] line_addr;
  logic          hit, req, acc, good, miss, flush_go, buf_clear, buf_full;

  assign line_addr = {s_axi_awaddr[AW-1:LB], LB'(0)};
  assign hit       = open_q && (line_addr == cur_line_q);
  assign req       = s_axi_awvalid && s_axi_wvalid;
  assign acc       = rstn && (state_q == ST_COLLECT) && !bvalid_q && req && (!open_q || hit);
  // Multi-beat slave writes are answered but never merged.
  assign good      = acc && (s_axi_awlen == 8'd0);
  assign miss      = req && open_q && !hit;
  // An accept in the same cycle always wins over any flush trigger.
  assign flush_go  = (state_q == ST_COLLECT) && open_q && !acc &&
                     (buf_full || miss || (tmo_q == '0) || flush_req || pend_q);

  always_comb begin
    state_d    = state_q;
    open_d     = open_q;
    cur_line_d = cur_line_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    beat_d     = beat_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    err_d      = err_q;
    buf_clear  = 1'b0;

    case (state_q)
      ST_COLLECT:  if (flush_go) state_d = ST_FLUSH_AW;
      ST_FLUSH_AW: begin
        if (m_axi_awready) begin
          state_d = ST_FLUSH_W;
          beat_d  = '0;
        end
      end
      ST_FLUSH_W: begin
        if (m_axi_wready) begin
          if (beat_q == LAST_BEAT) state_d = ST_FLUSH_B;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      ST_FLUSH_B: begin
        if (m_axi_bvalid) begin
          state_d   = ST_COLLECT;
          open_d    = 1'b0;
          buf_clear = 1'b1;
          if (m_axi_bresp != RESP_OKAY) err_d = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    if (good) begin
      open_d     = 1'b1;
      cur_line_d = line_addr;
      tmo_d      = TW'(C_FLUSH_TIMEOUT);
    end else if ((state_q == ST_COLLECT) && open_q && (tmo_q != '0)) begin
      tmo_d = tmo_q - 1'b1;
    end

    if (acc && !good) err_d = 1'b1;

    if (acc) begin
      bvalid_d = 1'b1;
      bid_d    = s_axi_awid;
      bresp_d  = good ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // A request with nothing to flush is dropped; one that lands mid-flush or
    // alongside a merge is held until the FSM can act on it.
    if (flush_req && ((state_q != ST_COLLECT) || open_q || acc)) pend_d = 1'b1;
    if (flush_go || ((state_q == ST_COLLECT) && !open_q && !acc)) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_COLLECT;
      open_q     <= 1'b0;
      cur_line_q <= '0;
      tmo_q      <= '0;
      pend_q     <= 1'b0;
      beat_q     <= '0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      open_q     <= open_d;
      cur_line_q <= cur_line_d;
      tmo_q      <= tmo_d;
      pend_q     <= pend_d;
      beat_q     <= beat_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      err_q      <= err_d;
    end
  end

  axi_wr_line_buf #(
    .BURST_LEN (C_M_AXI_BURST_LEN),
    .S_DW      (C_S_AXI_DATA_WIDTH),
    .M_DW      (C_M_AXI_DATA_WIDTH)
  ) u_line_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (good),
    .wr_word (s_axi_awaddr[LB-1:SB]),
    .wr_data (s_axi_wdata),
    .wr_strb (s_axi_wstrb),
    .clear   (buf_clear),
    .rd_beat (beat_q),
    .rd_data (m_axi_wdata),
    .rd_strb (m_axi_wstrb),
    .full    (buf_full)
  );

  assign s_axi_awready = acc;
  assign s_axi_wready  = acc;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = cur_line_q;
  assign m_axi_awlen   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi_awsize  = 3'(M_SIZE);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = (state_q == ST_FLUSH_AW);
  assign m_axi_wvalid  = (state_q == ST_FLUSH_W);
  assign m_axi_wlast   = (state_q == ST_FLUSH_W) && (beat_q == LAST_BEAT);
  assign m_axi_bready  = 1'b1;

  assign idle = !open_q && (state_q == ST_COLLECT) && !bvalid_q;
  assign err  = err_q;

  // Size/burst/wlast are implied by the single-beat contract; low address
  // bits below the word, and the master B id, carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_wlast,
                           s_axi_awaddr[SB-1:0], m_axi_bid};

endmodule

// File: tb/tb_axi_wr_coalesce.sv
module tb_axi_wr_coalesce;

  logic         clk = 1'b0;
  logic         rstn;
  logic [0:0]   s_axi_awid;
  logic [47:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic [2:0]   s_axi_awsize;
  logic [1:0]   s_axi_awburst;
  logic         s_axi_awvalid, s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [0:0]   s_axi_bid;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid, s_axi_bready;
  logic [0:0]   m_axi_awid;
  logic [47:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awlock;
  logic [3:0]   m_axi_awcache;
  logic [2:0]   m_axi_awprot;
  logic [3:0]   m_axi_awqos;
  logic         m_axi_awvalid, m_axi_awready;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [0:0]   m_axi_bid;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         flush_req, idle, err;

  axi_wr_coalesce dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .flush_req(flush_req), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int b_cnt = 0, m_aw_cnt = 0, s_acc_cnt = 0;
  logic [1:0] last_bresp = 2'b00;
  logic [0:0] last_bid = 1'b0;

  always @(posedge clk) begin
    if (s_axi_bvalid && s_axi_bready) begin
      b_cnt      <= b_cnt + 1;
      last_bresp <= s_axi_bresp;
      last_bid   <= s_axi_bid;
    end
    if (m_axi_awvalid && m_axi_awready) m_aw_cnt <= m_aw_cnt + 1;
    if (s_axi_awvalid && s_axi_awready) s_acc_cnt <= s_acc_cnt + 1;
  end

  // Captured flush
  logic [47:0]  f_addr;
  logic [7:0]   f_len;
  logic [2:0]   f_size;
  logic [1:0]   f_burst;
  logic [3:0]   f_cache;
  int           aw_wait, w_cycles;
  logic [255:0] cap_data [16];
  logic [31:0]  cap_strb [16];
  logic         cap_last [16];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic s_write(input logic [47:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [7:0] len, input logic id);
    int guard;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awlen = len; s_axi_awid = id;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    guard = 0;
    #1;
    while (!s_axi_awready && guard < 400) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!s_axi_awready) chk("s_accept_timeout", 256'd0, 256'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic run_flush(input logic [1:0] resp, input bit toggle);
    int k;
    bit wr;
    aw_wait = 0;
    while (!m_axi_awvalid && aw_wait < 300) begin
      tick();
      aw_wait++;
    end
    if (!m_axi_awvalid) begin
      chk("m_aw_timeout", 256'd0, 256'd1);
      return;
    end
    f_addr = m_axi_awaddr; f_len = m_axi_awlen; f_size = m_axi_awsize;
    f_burst = m_axi_awburst; f_cache = m_axi_awcache;
    m_axi_awready = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    k = 0; w_cycles = 0; wr = 1'b1;
    while (k < 16 && w_cycles < 200) begin
      m_axi_wready = toggle ? wr : 1'b1;
      wr = ~wr;
      #1;
      if (m_axi_wvalid && m_axi_wready) begin
        cap_data[k] = m_axi_wdata;
        cap_strb[k] = m_axi_wstrb;
        cap_last[k] = m_axi_wlast;
        k++;
      end
      @(posedge clk); #1;
      w_cycles++;
    end
    m_axi_wready = 1'b0;
    if (k != 16) begin
      chk("m_w_timeout", 256'(k), 256'd16);
      return;
    end
    m_axi_bvalid = 1'b1; m_axi_bresp = resp;
    tick();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
  endtask

  initial begin
    logic [255:0] exp_d;
    int a0, m0;

    rstn = 1'b0; flush_req = 1'b0;
    s_axi_awid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_wdata = '0; s_axi_wstrb = 4'h0; s_axi_wlast = 1'b1;
    s_axi_bready = 1'b1;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;

    // Reset state (slave valids held high to see awready stay low)
    tick(); tick();
    chk("rst_awready", 256'(s_axi_awready), 256'd0);
    chk("rst_idle", 256'(idle), 256'd1);
    chk("rst_err", 256'(err), 256'd0);
    chk("rst_valids", 256'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid}), 256'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    rstn = 1'b1;
    tick();

    // T1: 8 words 0x1000..0x101C, drained by idle timeout
    for (int i = 0; i < 8; i++) s_write(48'h1000 + 48'(4 * i), 32'(i), 4'hF, 8'd0, 1'b0);
    chk("t1_idle_open", 256'(idle), 256'd0);
    run_flush(2'b00, 1'b0);
    chk("t1_aw_wait", 256'(aw_wait), 256'd65);
    chk("t1_addr", 256'(f_addr), 256'h1000);
    chk("t1_len", 256'(f_len), 256'd15);
    chk("t1_size", 256'(f_size), 256'd5);
    chk("t1_burst", 256'(f_burst), 256'd1);
    chk("t1_cache", 256'(f_cache), 256'd2);
    for (int j = 0; j < 8; j++) exp_d[j*32 +: 32] = 32'(j);
    chk("t1_data0", cap_data[0], exp_d);
    chk("t1_strb0", 256'(cap_strb[0]), 256'hFFFF_FFFF);
    for (int k = 1; k < 16; k++) chk($sformatf("t1_strb%0d", k), 256'(cap_strb[k]), 256'd0);
    chk("t1_last", 256'({cap_last[15], cap_last[14]}), 256'b10);
    chk("t1_bresp", 256'(last_bresp), 256'd0);
    tick();
    chk("t1_idle_after", 256'(idle), 256'd1);

    // T2: full line 0x2000..0x21FC flushes straight after the last accept
    for (int i = 0; i < 128; i++)
      s_write(48'h2000 + 48'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 8'd0, 1'b0);
    run_flush(2'b00, 1'b0);
    chk("t2_aw_wait", 256'(aw_wait), 256'd1);
    chk("t2_addr", 256'(f_addr), 256'h2000);
    chk("t2_w_cycles", 256'(w_cycles), 256'd16);
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 8; j++) exp_d[j*32 +: 32] = 32'hC0DE_0000 + 32'(k * 8 + j);
      chk($sformatf("t2_data%0d", k), cap_data[k], exp_d);
      chk($sformatf("t2_strb%0d", k), 256'(cap_strb[k]), 256'hFFFF_FFFF);
    end

    // T3: miss on open line stalls until the old line's B
    s_write(48'h3000, 32'h1111_3000, 4'hF, 8'd0, 1'b0);
    a0 = s_acc_cnt;
    s_axi_awaddr = 48'h3200; s_axi_wdata = 32'h2222_3200; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    chk("t3_stall0", 256'(s_axi_awready), 256'd0);
    tick();
    chk("t3_stall1", 256'(s_axi_awready), 256'd0);
    run_flush(2'b00, 1'b0);
    chk("t3_addr", 256'(f_addr), 256'h3000);
    chk("t3_data0", 256'(cap_data[0][31:0]), 256'h1111_3000);
    chk("t3_not_taken", 256'(s_acc_cnt - a0), 256'd0);
    chk("t3_ready_after_b", 256'(s_axi_awready), 256'd1);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("t3_taken", 256'(s_acc_cnt - a0), 256'd1);
    pulse_flush();
    run_flush(2'b00, 1'b0);
    chk("t3_addr2", 256'(f_addr), 256'h3200);
    chk("t3_data2", 256'(cap_data[0][31:0]), 256'h2222_3200);

    // T4: byte merge, last write wins
    s_write(48'h4004, 32'hAAAA_AAAA, 4'hF, 8'd0, 1'b0);
    s_write(48'h4004, 32'h0000_0055, 4'h1, 8'd0, 1'b0);
    pulse_flush();
    run_flush(2'b00, 1'b0);
    chk("t4_addr", 256'(f_addr), 256'h4000);
    chk("t4_word1", 256'(cap_data[0][63:32]), 256'hAAAA_AA55);
    chk("t4_strb0", 256'(cap_strb[0]), 256'h0000_00F0);

    // T5: wready toggling, SLVERR from master
    for (int k = 0; k < 16; k++)
      s_write(48'h5000 + 48'(32 * k), 32'h5000_0000 + 32'(k), 4'hF, 8'd0, 1'b0);
    chk("t5_err_before", 256'(err), 256'd0);
    pulse_flush();
    run_flush(2'b10, 1'b1);
    chk("t5_w_cycles", 256'(w_cycles), 256'd31);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t5_data%0d", k), 256'(cap_data[k][31:0]), 256'(32'h5000_0000 + 32'(k)));
      chk($sformatf("t5_strb%0d", k), 256'(cap_strb[k]), 256'h0000_000F);
      chk($sformatf("t5_last%0d", k), 256'(cap_last[k]), 256'(k == 15));
    end
    chk("t5_err", 256'(err), 256'd1);
    repeat (5) tick();
    chk("t5_err_sticky", 256'(err), 256'd1);

    // Reset clears err; empty flush_req is a no-op
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    chk("t6_err_cleared", 256'(err), 256'd0);
    m0 = m_aw_cnt;
    pulse_flush();
    repeat (5) tick();
    chk("t6_empty_idle", 256'(idle), 256'd1);
    chk("t6_empty_no_aw", 256'(m_aw_cnt - m0), 256'd0);

    // T7: awlen != 0 -> SLVERR, err, no master traffic
    s_write(48'h7000, 32'hDEAD_BEEF, 4'hF, 8'd3, 1'b1);
    tick();
    chk("t7_bresp", 256'(last_bresp), 256'd2);
    chk("t7_bid", 256'(last_bid), 256'd1);
    chk("t7_err", 256'(err), 256'd1);
    repeat (80) tick();
    chk("t7_no_aw", 256'(m_aw_cnt - m0), 256'd0);
    chk("t7_idle", 256'(idle), 256'd1);

    // T8: reset in the middle of the wide data phase
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    s_write(48'h6000, 32'h6666_6666, 4'hF, 8'd0, 1'b0);
    pulse_flush();
    a0 = 0;
    while (!m_axi_awvalid && a0 < 50) begin tick(); a0++; end
    chk("t8_aw_seen", 256'(m_axi_awvalid), 256'd1);
    m_axi_awready = 1'b1; tick(); m_axi_awready = 1'b0;
    chk("t8_in_w", 256'(m_axi_wvalid), 256'd1);
    m0 = m_aw_cnt;
    rstn = 1'b0;
    tick();
    chk("t8_rst_valids", 256'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid}), 256'd0);
    chk("t8_rst_idle", 256'(idle), 256'd1);
    chk("t8_rst_err", 256'(err), 256'd0);
    rstn = 1'b1;
    repeat (80) tick();
    chk("t8_discarded", 256'(m_aw_cnt - m0), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
